// File: rtl/board_pkg.sv
// Shared types and board-size defaults for the Game-of-Life board and its serial transmitter.
package board_pkg;

    localparam int unsigned ROWS_DEF = 8;
    localparam int unsigned COLS_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

endpackage

// File: rtl/board_serializer_clk_div_tick.sv
// Free-running modulo-DIV counter; tick marks the last cycle of each DIV-cycle period.
module clk_div_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Held at zero while cleared, so the first period after clr drops is a full DIV cycles.
    assign tick = !clr && (cnt == TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/board_serializer.sv
// Snapshots the board and shifts it out on a data/clock/latch link (74HC595-style chain).
// Define BOARD_SERIALIZER_LSB_FIRST_EN to send cells[0] first instead of cells[N-1].
module board_serializer
    import board_pkg::*;
#(
    parameter int unsigned ROWS    = ROWS_DEF,
    parameter int unsigned COLS    = COLS_DEF,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] cells,
    output logic                 busy,
    output logic                 done,
    output logic                 sdata,
    output logic                 sclk,
    output logic                 slatch
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

`ifdef BOARD_SERIALIZER_LSB_FIRST_EN
    localparam logic [IW-1:0] IDX_FIRST = '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
`else
    localparam logic [IW-1:0] IDX_FIRST = IW'(N - 1);
    localparam logic [IW-1:0] IDX_LAST  = '0;
`endif

    state_t          state_q, state_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic [N-1:0]    snap_q, snap_n;
    logic            sclk_n;
    logic            tick;
    logic            div_clr;

    assign div_clr = (state_q == S_IDLE) || (state_q == S_DONE);

    clk_div_tick #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .tick (tick)
    );

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        snap_n  = snap_q;
        sclk_n  = sclk;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_n  = cells;
                    idx_n   = IDX_FIRST;
                    sclk_n  = 1'b0;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_n = S_LATCH;
                        end else begin
`ifdef BOARD_SERIALIZER_LSB_FIRST_EN
                            idx_n = idx_q + IW'(1);
`else
                            idx_n = idx_q - IW'(1);
`endif
                        end
                    end
                end
            end
            S_LATCH: begin
                sclk_n = 1'b0;
                if (tick) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Every output is a flop fed from the next-state decode, so pins never see start/cells directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sdata   <= 1'b0;
            sclk    <= 1'b0;
            slatch  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            snap_q  <= snap_n;
            busy    <= (state_n == S_SHIFT) || (state_n == S_LATCH);
            done    <= (state_n == S_DONE);
            sdata   <= (state_n == S_SHIFT) ? snap_n[idx_n] : 1'b0;
            sclk    <= (state_n == S_SHIFT) && sclk_n;
            slatch  <= (state_n == S_LATCH);
        end
    end

endmodule

// File: tb/tb_board_serializer.sv
// Self-checking bench for board_serializer (2x2 board, CLK_DIV=2) with a cycle-accurate frame model.
module tb_board_serializer;

    localparam int R = 2;
    localparam int C = 2;
    localparam int D = 2;
    localparam int N = R * C;
    localparam int LATCH_START = 2 * N * D + 1;
    localparam int FRAME_END   = (2 * N + 1) * D;
    localparam int DONE_REL    = FRAME_END + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] cells = '0;
    logic         busy, done, sdata, sclk, slatch;

    int n_checks = 0;
    int n_errors = 0;
    int rel = 0;
    logic [0:0] exp_q[$];
    logic prev_sclk_exp = 1'b0;

    always #5 clk = ~clk;

    board_serializer #(
        .ROWS    (R),
        .COLS    (C),
        .CLK_DIV (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cells  (cells),
        .busy   (busy),
        .done   (done),
        .sdata  (sdata),
        .sclk   (sclk),
        .slatch (slatch)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // rel = periods elapsed since the accepting edge (0 means idle).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rel = 0;
            exp_q.delete();
        end else if (rel == 0) begin
            if (start) begin
                rel = 1;
                for (int i = 0; i < N; i++) begin
`ifdef BOARD_SERIALIZER_LSB_FIRST_EN
                    exp_q.push_back(cells[i]);
`else
                    exp_q.push_back(cells[N-1-i]);
`endif
                end
            end
        end else if (rel == DONE_REL) begin
            rel = 0;
        end else begin
            rel++;
        end
    end

    always @(negedge clk) begin : mon
        logic e_busy, e_latch, e_done, e_sclk, e_shift;
        logic [0:0] b;
        e_shift = (rel >= 1) && (rel < LATCH_START);
        e_busy  = (rel >= 1) && (rel <= FRAME_END);
        e_latch = (rel >= LATCH_START) && (rel <= FRAME_END);
        e_done  = (rel == DONE_REL);
        e_sclk  = e_shift && ((((rel - 1) / D) % 2) == 1);
        check("busy", busy, e_busy);
        check("slatch", slatch, e_latch);
        check("done", done, e_done);
        check("sclk", sclk, e_sclk);
        if (e_sclk && !prev_sclk_exp) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("sdata", sdata, b);
            end
        end else if (!e_shift) begin
            check("sdata_idle", sdata, 0);
        end
        if (e_done) check("q_empty", exp_q.size(), 0);
        prev_sclk_exp = e_sclk;
    end

    task automatic send(input logic [N-1:0] v);
        @(negedge clk);
        cells = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (DONE_REL + 3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        rst = 1'b0;

        // Long idle: nothing may move.
        repeat (100) @(negedge clk);

        send(4'b1010);

        // Cells change mid-frame; the snapshot must still go out.
        @(negedge clk);
        cells = 4'b1010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cells = 4'b0101;
        repeat (DONE_REL) @(negedge clk);

        // Start held high: back-to-back frames, nothing queued while busy.
        @(negedge clk);
        cells = 4'b0110;
        start = 1'b1;
        repeat (2 * (DONE_REL + 1) + 5) @(negedge clk);
        start = 1'b0;
        repeat (DONE_REL + 3) @(negedge clk);

        send(4'b0001);
        send(4'b1000);
        for (int k = 0; k < 6; k++) begin
            send(N'($urandom_range(0, (1 << N) - 1)));
        end

        // Asynchronous reset while sclk and sdata are high.
        @(negedge clk);
        cells = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && rel != 3; k++) @(negedge clk);
        check("reach_mid_frame", rel, 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sclk", sclk, 0);
        check("arst_sdata", sdata, 0);
        check("arst_slatch", slatch, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(4'b1011);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/board_serializer.md
Name: board_serializer

Overview:
- Transmit side of the Game-of-Life board: snapshots the flattened grid of `state_q` outputs on request.
- Shifts the snapshot out on a 3-wire serial link (data/clock/latch) to an external shift-register LED chain, e.g. a 74HC595 cascade.
- Sits between the cell array and the board pins. Software/top-level FSM pulses `start` once per generation, after the cells' `ena` step.

Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns; N = ROWS*COLS bits per frame.
- CLK_DIV, 4, clk cycles per sclk half-period; legal range ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request frame transmit; sampled every cycle.
- cells  input  ROWS*COLS  board state; cell (r,c) at bit r*COLS+c.
- busy  output  1  high while a frame is in flight (SHIFT or LATCH).
- done  output  1  one-cycle pulse when a frame completes.
- sdata  output  1  serial data; changes only while sclk is low.
- sclk  output  1  serial clock; receiver samples on rising edge.
- slatch  output  1  latch strobe; high for CLK_DIV cycles after the last bit.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, sdata, sclk and slatch all 0; bit index 0; divider 0.
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE:
  - When start=1 at an edge, copy cells into the snapshot register, set index = N-1, divider = 0, and go to SHIFT.
  - Otherwise hold; `cells` is not sampled.
- SHIFT: sdata = snapshot[index]. Each bit takes 2*CLK_DIV cycles:
  - sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - At the end of the high phase, sclk returns to 0 and index decrements.
  - After the bit at index 0 completes its high phase, go to LATCH.
- LATCH: sclk=0, sdata=0, slatch=1 for exactly CLK_DIV cycles, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Busy is high in SHIFT and LATCH only.
- Latency: start accepted at edge T.
  - SHIFT occupies cycles T+1 .. T+2*N*CLK_DIV.
  - LATCH occupies the next CLK_DIV cycles.
  - done is high in cycle T+(2N+1)*CLK_DIV+1.
- start while busy=1 or in DONE: ignored, not queued.
- Changes to cells during a frame: no effect; the snapshot alone is transmitted.
- Reset mid-frame: outputs drop to 0 asynchronously, no latch pulse, no done pulse; the next start transmits a full frame.
- Divider and index widths: $clog2 of CLK_DIV and N, minimum 1 bit each. Index never wraps below 0; the transition to LATCH is decided at index==0.
- All outputs are registered; no combinational path from start or cells to any output.

Optional Feature:
- Macro: BOARD_SERIALIZER_LSB_FIRST_EN.
- Defined: index starts at 0 and increments. Bit order is cells[0] first, cells[N-1] last. The transition to LATCH is decided at index==N-1.
- Undefined (default): MSB-first, exactly as described above.
- Frame timing is identical in both modes.

Decomposition:
- Package board_pkg holds:
  - the state enum typedef (S_IDLE, S_SHIFT, S_LATCH, S_DONE);
  - default ROWS/COLS localparams shared with the cell array top.
- One sub-module, clk_div_tick: a CLK_DIV counter with clr input, emitting a one-cycle `tick` on terminal count. It drives the sclk phase toggles and the LATCH duration.

Test Plan:
- ROWS=COLS=2, CLK_DIV=2, cells=4'b1010, start pulse at cycle 0 -> sdata sampled on sclk rises reads 1,0,1,0; rises at cycles 3,7,11,15; slatch high cycles 17–18; done high cycle 19 only; busy high cycles 1–18.
- Same config, cells toggled to 4'b0101 at cycle 5 -> transmitted bits remain 1,0,1,0.
- Same config, start held high continuously -> back-to-back frames; second frame's first sclk rise at cycle 23; no start accepted while busy.
- ROWS=COLS=8, CLK_DIV=1, rst asserted at cycle 40 mid-SHIFT -> sclk/sdata/busy drop to 0 same cycle; no slatch, no done; a later start yields a full 64-bit frame.
- With BOARD_SERIALIZER_LSB_FIRST_EN, 2x2, CLK_DIV=2, cells=4'b0001 -> bits 1,0,0,0; timing identical to test 1.
- CLK_DIV=1, N=4, idle with start=0 for 100 cycles -> all outputs stay 0, busy=0.
